// File: rtl/nios2_div_pkg.sv
// Shared types and helpers for the Nios II iterative divide cell.
//   state_t   : divider control states
//   DIV0_QUOT : quotient returned on divide-by-zero (all ones, truncated by user)
//   abs_w     : conditional two's-complement magnitude on MAX_W bits
package nios2_div_pkg;

   // Widest datapath the helpers support; users truncate to their own width.
   localparam int unsigned MAX_W = 64;

   localparam logic [MAX_W-1:0] DIV0_QUOT = '1;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      RUN  = 3'd2,
      FIX  = 3'd3,
      DONE = 3'd4
   } state_t;

   // Negate when neg is set; low bits of the result are exact for any narrower width.
   function automatic logic [MAX_W-1:0] abs_w(input logic [MAX_W-1:0] x, input logic neg);
      return neg ? (~x + MAX_W'(1)) : x;
   endfunction

endpackage

// File: rtl/nios2_qsys_0_div_cell_step.sv
// Single restoring-division step (combinational).
//   rem      : current partial remainder
//   dvd      : dividend / quotient shift register
//   dsr      : divisor magnitude
//   rem_next : partial remainder after this step
//   dvd_next : dividend shifted left with the new quotient bit in the LSB
module nios2_div_step #(
   parameter int unsigned DATA_W = 32
) (
   input  logic [DATA_W-1:0] rem,
   input  logic [DATA_W-1:0] dvd,
   input  logic [DATA_W-1:0] dsr,
   output logic [DATA_W-1:0] rem_next,
   output logic [DATA_W-1:0] dvd_next
);

   logic [DATA_W:0] shifted;
   logic [DATA_W:0] trial;

   // rem < dsr always holds, so the true difference fits in DATA_W+1 signed bits.
   always_comb begin
      shifted = {rem, dvd[DATA_W-1]};
      trial   = shifted - {1'b0, dsr};
      if (!trial[DATA_W]) begin
         rem_next = trial[DATA_W-1:0];
         dvd_next = {dvd[DATA_W-2:0], 1'b1};
      end else begin
         rem_next = shifted[DATA_W-1:0];
         dvd_next = {dvd[DATA_W-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/nios2_qsys_0_div_cell.sv
// Iterative radix-2 restoring divider (div/divu) for the Nios II A-stage.
//   clk, reset_n       : clock, asynchronous active-low reset
//   A_div_src1/src2    : dividend / divisor
//   A_div_signed       : 1 = signed (div), 0 = unsigned (divu); sampled with start
//   A_div_start        : request pulse, accepted only in IDLE
//   A_div_busy         : high during LOAD/RUN/FIX
//   A_div_done         : one-cycle strobe, results valid and held afterwards
//   A_div_cell_result  : quotient
//   A_div_cell_rem     : remainder
// Latency: start accepted at the end of cycle 0 gives done in cycle DATA_W+3.
// DATA_W must be even, >= 4 and <= nios2_div_pkg::MAX_W; 2^CNT_W > DATA_W.
module nios2_qsys_0_div_cell #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CNT_W  = 6
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [DATA_W-1:0] A_div_src1,
   input  logic [DATA_W-1:0] A_div_src2,
   input  logic              A_div_signed,
   input  logic              A_div_start,
   output logic              A_div_busy,
   output logic              A_div_done,
   output logic [DATA_W-1:0] A_div_cell_result,
   output logic [DATA_W-1:0] A_div_cell_rem
);

   import nios2_div_pkg::*;

   state_t            state, state_next;
   logic              busy_next, done_next;

   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] rem, dvd, dsr, orig;
   logic              sgn, q_neg, r_neg, div0;
   logic [DATA_W-1:0] rem_step, dvd_step;

   nios2_div_step #(.DATA_W(DATA_W)) u_step (
      .rem      (rem),
      .dvd      (dvd),
      .dsr      (dsr),
      .rem_next (rem_step),
      .dvd_next (dvd_step)
   );

   // State and status flag registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         A_div_busy <= 1'b0;
         A_div_done <= 1'b0;
      end else begin
         state      <= state_next;
         A_div_busy <= busy_next;
         A_div_done <= done_next;
      end
   end

   // Next state; busy/done are decoded from the next state so they register with it.
   always_comb begin
      state_next = state;
      busy_next  = 1'b0;
      done_next  = 1'b0;
      case (state)
         IDLE:    if (A_div_start) state_next = LOAD;
         LOAD:    state_next = RUN;
         RUN:     if (cnt == CNT_W'(1)) state_next = FIX;
         FIX:     state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
      busy_next = (state_next == LOAD) || (state_next == RUN) || (state_next == FIX);
      done_next = (state_next == DONE);
   end

   // Operand capture, iteration datapath and sign fixup.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt               <= '0;
         rem               <= '0;
         dvd               <= '0;
         dsr               <= '0;
         orig              <= '0;
         sgn               <= 1'b0;
         q_neg             <= 1'b0;
         r_neg             <= 1'b0;
         div0              <= 1'b0;
         A_div_cell_result <= '0;
         A_div_cell_rem    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (A_div_start) begin
                  dvd  <= A_div_src1;
                  dsr  <= A_div_src2;
                  orig <= A_div_src1;
                  sgn  <= A_div_signed;
               end
            end
            LOAD: begin
               dvd   <= DATA_W'(abs_w(MAX_W'(dvd), sgn & dvd[DATA_W-1]));
               dsr   <= DATA_W'(abs_w(MAX_W'(dsr), sgn & dsr[DATA_W-1]));
               q_neg <= sgn & (dvd[DATA_W-1] ^ dsr[DATA_W-1]);
               r_neg <= sgn & dvd[DATA_W-1];
               div0  <= (dsr == '0);
               rem   <= '0;
               cnt   <= CNT_W'(DATA_W);
            end
            RUN: begin
               rem <= rem_step;
               dvd <= dvd_step;
               cnt <= cnt - CNT_W'(1);
            end
            FIX: begin
               // Divide-by-zero returns all ones and the untouched dividend in both modes.
               if (div0) begin
                  A_div_cell_result <= DATA_W'(DIV0_QUOT);
                  A_div_cell_rem    <= orig;
               end else begin
                  A_div_cell_result <= DATA_W'(abs_w(MAX_W'(dvd), q_neg));
                  A_div_cell_rem    <= DATA_W'(abs_w(MAX_W'(rem), r_neg));
               end
            end
            default: ;
         endcase
      end
   end

endmodule
